// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the WISC unified-memory arbiter: FSM state encoding
// and the instruction returned to fetch when an access is aborted.
package wisc_mem_pkg;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_BUSY_IF  = 2'b01;
  localparam logic [1:0] ST_BUSY_MEM = 2'b10;

  // NOP handed to fetch when its access times out, so the pipeline keeps moving
  localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/wisc_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at MAX until cleared.
module wisc_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Count up on inc, hold at MAX, return to zero on clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != MAX_VAL)) begin
      count_r <= count_r + ONE_VAL;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/wisc_mem_arbiter.sv
// Arbiter sharing the unified mem_system between fetch and memory stage.
// One access at a time, latched for the whole cache transaction; memory stage
// has priority, bounded by a starvation counter; a watchdog aborts hung
// accesses and raises a sticky error.
module wisc_mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_data,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        mem_done,
  output logic [15:0] mem_rdata,
  output logic        mem_stall,
  input  logic        dump,
  output logic [15:0] c_addr,
  output logic [15:0] c_wdata,
  output logic        c_rd,
  output logic        c_wr,
  output logic        c_dump,
  input  logic [15:0] c_rdata,
  input  logic        c_done,
  input  logic        c_err,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [15:0]   addr_r;
  logic [15:0]   wdata_r;
  logic          wr_r;
  logic          err_r;
  logic [SW-1:0] starve_cnt_s;
  logic [WW-1:0] wd_cnt_s;

  logic idle_s, busy_if_s, busy_mem_s, busy_s;
  logic starve_hit_s, grant_mem_s, grant_if_s;
  logic timeout_s, finish_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign busy_if_s  = (state_r == ST_BUSY_IF);
  assign busy_mem_s = (state_r == ST_BUSY_MEM);
  assign busy_s     = busy_if_s | busy_mem_s;

  // While dumping, a pending memory request is still drained, even past the
  // starvation limit, since fetch cannot be granted then.
  assign starve_hit_s = (starve_cnt_s == SW'(STARVE_LIMIT));
  assign grant_mem_s  = idle_s & mem_req & (~if_req | ~starve_hit_s | dump);
  assign grant_if_s   = idle_s & if_req & ~grant_mem_s & ~dump;

  assign timeout_s = busy_s & (wd_cnt_s == WW'(TIMEOUT));
  assign finish_s  = busy_s & (c_done | timeout_s);

  wisc_sat_counter #(.WIDTH(SW), .MAX(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr   (~if_req | grant_if_s),
    .inc   (grant_mem_s & if_req),
    .count (starve_cnt_s)
  );

  wisc_sat_counter #(.WIDTH(WW), .MAX(TIMEOUT)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (~busy_s),
    .inc   (busy_s),
    .count (wd_cnt_s)
  );

  // Grant in IDLE, return to IDLE on cache completion or watchdog abort
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_mem_s) begin
          state_nxt_s = ST_BUSY_MEM;
        end else if (grant_if_s) begin
          state_nxt_s = ST_BUSY_IF;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (finish_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the granted request so the cache port stays stable until Done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      wr_r    <= 1'b0;
    end else if (grant_mem_s) begin
      addr_r  <= mem_addr;
      wdata_r <= mem_wdata;
      wr_r    <= mem_wr;
    end else if (grant_if_s) begin
      addr_r  <= if_addr;
      wdata_r <= 16'h0000;
      wr_r    <= 1'b0;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wr_r    <= wr_r;
    end
  end

  // Sticky error from the cache or a watchdog abort; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (c_err || timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Completion data: cache data normally, NOP / zero on abort, 0 when idle
  always_comb begin
    if_data   = 16'h0000;
    mem_rdata = 16'h0000;
    if (if_done) begin
      if_data = timeout_s ? NOP_INSTR : c_rdata;
    end else begin
      if_data = 16'h0000;
    end
    if (mem_done) begin
      mem_rdata = timeout_s ? 16'h0000 : c_rdata;
    end else begin
      mem_rdata = 16'h0000;
    end
  end

  assign c_addr   = addr_r;
  assign c_wdata  = wdata_r;
  assign c_rd     = (busy_if_s | (busy_mem_s & ~wr_r)) & ~timeout_s;
  assign c_wr     = busy_mem_s & wr_r & ~timeout_s;
  assign if_done  = busy_if_s & (c_done | timeout_s);
  assign mem_done = busy_mem_s & (c_done | timeout_s);

  // Request-derived outputs are held low while reset is asserted
  assign if_stall  = if_req & ~if_done & rst;
  assign mem_stall = mem_req & ~mem_done & rst;
  assign c_dump    = dump & idle_s & ~if_req & ~mem_req & rst;
  assign err       = err_r;

endmodule

// File: doc/wisc_mem_arbiter.md
# wisc_mem_arbiter

Shares the single unified `mem_system` instance between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the five-stage WISC pipeline. It latches one request at a time, holds it stable on the cache port until `Done`, returns data and completion to the owning requester, and stalls the other. Fixed priority to the memory stage is bounded by a starvation guard so fetch always progresses. A watchdog turns a hung access into an error.

## Interface
- `STARVE_LIMIT`, 4: consecutive memory-stage grants allowed while fetch waits; the next grant then goes to fetch.
- `TIMEOUT`, 64: cycles an access may remain outstanding before it is aborted with error.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held high until `if_done`.
- `if_addr`  in  16  fetch address (PC).
- `if_done`  out  1  one-cycle completion pulse to fetch.
- `if_data`  out  16  instruction; valid only with `if_done`.
- `if_stall`  out  1  `if_req & ~if_done`.
- `mem_req`  in  1  data request; held until `mem_done`.
- `mem_wr`  in  1  1 = store, 0 = load; sampled at grant.
- `mem_addr`, `mem_wdata`  in  16 each  data address / store data.
- `mem_done`  out  1  one-cycle completion pulse to memory stage.
- `mem_rdata`  out  16  load data; valid only with `mem_done`.
- `mem_stall`  out  1  `mem_req & ~mem_done`.
- `dump`  in  1  halt/dump request from the pipeline.
- `c_addr`, `c_wdata`  out  16 each  to cache `Addr` / `DataIn`.
- `c_rd`, `c_wr`  out  1 each  to cache `Rd` / `Wr`.
- `c_dump`  out  1  to cache `createdump`.
- `c_rdata`  in  16  cache `DataOut`.
- `c_done`  in  1  cache `Done`, one-cycle pulse.
- `c_err`  in  1  cache `err`.
- `err`  out  1  sticky error: cache error or watchdog timeout; cleared only by reset.

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE: if `mem_req` and (`if_req`=0 or starve count < `STARVE_LIMIT`): latch `mem_addr/mem_wdata/mem_wr` and go to BUSY_MEM. Otherwise, if `if_req`: latch `if_addr` and go to BUSY_IF.
- Starve counter (width clog2(`STARVE_LIMIT`+1)): +1 on each MEM grant while `if_req`=1, saturating. Cleared on any IF grant or while `if_req`=0.
- BUSY_x: `c_addr/c_wdata` come from latches, never from live inputs. BUSY_IF: `c_rd`=1, `c_wr`=0. BUSY_MEM: `c_rd`=~wr, `c_wr`=wr.
- `c_done`=1 in BUSY_x: pulse `x_done`, pass `c_rdata` to `x_data`, return to IDLE.
- Watchdog: counts cycles in BUSY. At `TIMEOUT`: drop `c_rd/c_wr`, pulse `x_done` with data 16'h0800 (NOP) for fetch or 0 for loads, set `err`, return to IDLE.
- `c_err`=1 in any cycle: set `err`. The access still completes normally on `c_done`.
- `c_dump` = `dump` & IDLE & ~`if_req` & ~`mem_req`. No new grants while `dump`=1, except to drain a `mem_req` already pending.
- `c_done` outside BUSY is ignored.

## Timing
- Reset (asynchronous assert): state IDLE, counters 0, latches 0, `err`=0, and all outputs 0, including `c_rd`, `c_wr`, `x_done` and `c_dump`.
- Request seen in IDLE at cycle N → `c_rd`/`c_wr` high from N+1 until the `c_done` cycle inclusive.
- `x_done` is combinational in the `c_done` cycle. Latency = 1 + cache latency.
- One IDLE bubble between accesses: the earliest next issue is 2 cycles after `c_done`.
- `if_req` and `mem_req` in the same IDLE cycle: memory wins unless the starve count equals `STARVE_LIMIT`.
- A request dropped mid-access is not cancelled; the access completes and `x_done` still pulses.

## Structure
- Shared package `wisc_mem_pkg`: state encoding (IDLE=2'b00, BUSY_IF=2'b01, BUSY_MEM=2'b10) and the NOP constant 16'h0800.
- One sub-module, `wisc_sat_counter` (parameterized width, clear, increment, saturate), instantiated for both the starve counter and the watchdog.

## Test plan
- Lone fetch: `if_req`, addr 0x0010, cache `Done` 2 cycles after issue with 0x1234 → `c_rd` high for 3 cycles, `if_done` pulses once, `if_data`=0x1234.
- Contention: both requests asserted at cycle 0 → MEM granted first (`c_wr` follows `mem_wr`), IF issued 2 cycles after MEM `c_done`.
- Starvation: `mem_req` always high with `if_req` high, `STARVE_LIMIT`=4 → exactly 4 MEM grants, then one IF grant, then the pattern repeats.
- Timeout: cache never asserts `Done` → after 64 BUSY cycles `c_rd` drops, `if_done` pulses with 0x0800, `err`=1 and stays 1.
- Reset mid-access: `rst` low during BUSY_MEM → outputs go to 0 immediately, state IDLE; after release a late `c_done` produces no `x_done`.
- Dump: `dump`=1 with `mem_req` pending → the store completes, then `c_dump`=1 while idle, and no further fetch grants occur.
